// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the memory stage of the RISC-V pipeline. It accepts
// one load or store per instruction over a valid/ready handshake, waits a
// configurable number of cycles to model access latency, and then returns the
// formatted load data for the MEM/WB register. While an access is in flight it
// raises StallM so that the hazard unit freezes the front of the pipeline.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   LATENCY     : cycles from acceptance to RespValid (1..15)
//
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous, active-high reset
//   ReqValidM   : memory stage presents a load or store
//   ReqWriteM   : 1 = store, 0 = load
//   Funct3M     : 000 B, 001 H, 010 W, 100 BU, 101 HU (others act as W)
//   AddrM       : byte address (wraps modulo the memory size)
//   WriteDataM  : right-aligned store data
//   ReqReady    : a request can be accepted this cycle
//   StallM      : request pending without a response yet
//   RespValid   : one-cycle completion pulse
//   ReadDataM   : formatted load data, held until the next response
//   MisalignM   : misaligned-access flag, valid with RespValid
//
// Configuration macro
//   DMEM_MISALIGN_CHK_EN : when defined, misaligned accesses are flagged on
//                          MisalignM, misaligned stores are dropped and
//                          misaligned loads return zero. When undefined, the
//                          offset is truncated to natural alignment and
//                          MisalignM stays 0.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ReqValidM,
   input  logic        ReqWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   output logic        ReqReady,
   output logic        StallM,
   output logic        RespValid,
   output logic [31:0] ReadDataM,
   output logic        MisalignM
);

   localparam int         AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Access width implied by funct3; undefined encodings behave as a word.
   function automatic logic [1:0] access_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: access_size = SZ_B;
         3'b001, 3'b101: access_size = SZ_H;
         default:        access_size = SZ_W;
      endcase
   endfunction

   // Drop offset bits below the natural alignment of the access.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    align_off = off;
         SZ_H:    align_off = {off[1], 1'b0};
         default: align_off = 2'b00;
      endcase
   endfunction

`ifdef DMEM_MISALIGN_CHK_EN
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_B:    is_misaligned = 1'b0;
         SZ_H:    is_misaligned = off[0];
         default: is_misaligned = (off != 2'b00);
      endcase
   endfunction
`endif

   // Lane select plus sign/zero extension of a load.
   function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      if (off[1]) begin
         h = word[31:16];
      end else begin
         h = word[15:0];
      end
      case (f3)
         3'b000:  format_load = {{24{b[7]}}, b};
         3'b100:  format_load = {24'd0, b};
         3'b001:  format_load = {{16{h[15]}}, h};
         3'b101:  format_load = {16'd0, h};
         default: format_load = word;
      endcase
   endfunction

   // Merge store data into the addressed lane(s), leaving other lanes intact.
   function automatic logic [31:0] merge_store(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] old, input logic [31:0] wd);
      logic [31:0] w;
      w = old;
      case (size)
         SZ_B: begin
            case (off)
               2'd0:    w[7:0]   = wd[7:0];
               2'd1:    w[15:8]  = wd[7:0];
               2'd2:    w[23:16] = wd[7:0];
               default: w[31:24] = wd[7:0];
            endcase
         end
         SZ_H: begin
            if (off[1]) begin
               w[31:16] = wd[15:0];
            end else begin
               w[15:0] = wd[15:0];
            end
         end
         default: w = wd;
      endcase
      merge_store = w;
   endfunction

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic [2:0]      f3_q, f3_d;
   logic [AW+1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            mis_q, mis_d;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            req_wr_s;
   logic [2:0]      req_f3_s;
   logic [AW+1:0]   req_addr_s;
   logic [31:0]     req_wdata_s;
   logic [1:0]      size_s;
   logic [1:0]      off_s;
   logic [AW-1:0]   idx_s;
   logic [31:0]     old_word_s;
   logic            mis_flag_s;
   logic            commit_s;
   logic            mem_we_s;
   logic [31:0]     mem_wdata_s;
   logic            unused_addr_s;

   // Address bits above the array size are intentionally ignored (wrap).
   assign unused_addr_s = ^AddrM[31:AW+2];

   // Request fields seen by the commit logic: live inputs when committing
   // straight out of IDLE (LATENCY = 1), latched copies otherwise.
   always_comb begin
      if (state_q == IDLE) begin
         req_wr_s    = ReqWriteM;
         req_f3_s    = Funct3M;
         req_addr_s  = AddrM[AW+1:0];
         req_wdata_s = WriteDataM;
      end else begin
         req_wr_s    = wr_q;
         req_f3_s    = f3_q;
         req_addr_s  = addr_q;
         req_wdata_s = wdata_q;
      end
   end

   // Commit datapath: lane/offset decode, misalign policy, store merge.
   always_comb begin
      size_s     = access_size(req_f3_s);
      off_s      = align_off(size_s, req_addr_s[1:0]);
      idx_s      = req_addr_s[AW+1:2];
      old_word_s = mem_q[idx_s];
`ifdef DMEM_MISALIGN_CHK_EN
      mis_flag_s = is_misaligned(size_s, req_addr_s[1:0]);
`else
      mis_flag_s = 1'b0;
`endif
      commit_s    = (state_d == DONE);
      mem_we_s    = commit_s && req_wr_s && !mis_flag_s;
      mem_wdata_s = merge_store(size_s, off_s, old_word_s, req_wdata_s);
   end

   // Next-state, request latch and response register computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (ReqValidM) begin
               wr_d    = ReqWriteM;
               f3_d    = Funct3M;
               addr_d  = AddrM[AW+1:0];
               wdata_d = WriteDataM;
               cnt_d   = LAT_M1;
               if (LATENCY == 1) begin
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Response data is captured only on the edge that enters DONE.
   always_comb begin
      if (commit_s) begin
         mis_d = mis_flag_s;
         if (req_wr_s || mis_flag_s) begin
            rdata_d = 32'd0;
         end else begin
            rdata_d = format_load(req_f3_s, off_s, old_word_s);
         end
      end else begin
         mis_d   = mis_q;
         rdata_d = rdata_q;
      end
   end

   // FSM and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= {(AW+2){1'b0}};
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   // Storage array; not reset, and a reset cancels any pending store.
   always_ff @(posedge clk) begin
      if (!reset && mem_we_s) begin
         mem_q[idx_s] <= mem_wdata_s;
      end
   end

   assign ReqReady  = (state_q == IDLE);
   assign StallM    = ((state_q == IDLE) && ReqValidM) || (state_q == BUSY);
   assign RespValid = (state_q == DONE);
   assign ReadDataM = rdata_q;
   assign MisalignM = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed testbench for dmem_responder (default DEPTH_WORDS=256, LATENCY=2).
// Each access drives a request on a falling edge, keeps ReqValidM high until
// RespValid appears (as the stalled pipeline would), and checks data, flag,
// latency and stall length against hand-computed values. Honors the
// DMEM_MISALIGN_CHK_EN macro for the misaligned-access expectations.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        ReqValidM;
   logic        ReqWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] AddrM;
   logic [31:0] WriteDataM;
   logic        ReqReady;
   logic        StallM;
   logic        RespValid;
   logic [31:0] ReadDataM;
   logic        MisalignM;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY    (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ReqValidM (ReqValidM),
      .ReqWriteM (ReqWriteM),
      .Funct3M   (Funct3M),
      .AddrM     (AddrM),
      .WriteDataM(WriteDataM),
      .ReqReady  (ReqReady),
      .StallM    (StallM),
      .RespValid (RespValid),
      .ReadDataM (ReadDataM),
      .MisalignM (MisalignM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index, advanced on every active edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access: drive, hold valid until RespValid, check everything.
   task automatic do_access(input string tag, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_mis,
                            output int acc_cyc, output int resp_cyc);
      bit          got;
      int          stalls;
      logic [31:0] rd;
      logic        mis;
      logic        rdy_done;
      got      = 1'b0;
      stalls   = 0;
      rd       = 32'd0;
      mis      = 1'b0;
      rdy_done = 1'b1;
      resp_cyc = -1;
      @(negedge clk);
      ReqValidM  = 1'b1;
      ReqWriteM  = w;
      Funct3M    = f3;
      AddrM      = a;
      WriteDataM = wd;
      #1;
      acc_cyc = cyc;
      check_value({tag, " ready"}, {31'd0, ReqReady}, 32'd1);
      for (int k = 0; k < 20; k++) begin
         if (StallM) stalls++;
         if (RespValid) begin
            got      = 1'b1;
            rd       = ReadDataM;
            mis      = MisalignM;
            rdy_done = ReqReady;
            resp_cyc = cyc;
            break;
         end
         @(negedge clk);
         #1;
      end
      check_value({tag, " resp_seen"}, {31'd0, got}, 32'd1);
      check_value({tag, " latency"}, 32'(resp_cyc - acc_cyc), 32'd2);
      check_value({tag, " stall_cycles"}, 32'(stalls), 32'd2);
      check_value({tag, " ready_in_done"}, {31'd0, rdy_done}, 32'd0);
      check_value({tag, " data"}, rd, exp_rd);
      check_value({tag, " misalign"}, {31'd0, mis}, {31'd0, exp_mis});
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ReqValidM = 1'b0;
   endtask

   initial begin
      int  a0, r0, a1, r1;
      bit  seen;
      reset      = 1'b1;
      ReqValidM  = 1'b0;
      ReqWriteM  = 1'b0;
      Funct3M    = 3'd0;
      AddrM      = 32'd0;
      WriteDataM = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_value("rst ReqReady",  {31'd0, ReqReady},  32'd1);
      check_value("rst StallM",    {31'd0, StallM},    32'd0);
      check_value("rst RespValid", {31'd0, RespValid}, 32'd0);
      check_value("rst ReadDataM", ReadDataM,          32'h0000_0000);
      check_value("rst MisalignM", {31'd0, MisalignM}, 32'd0);
      reset = 1'b0;

      // Word store then load
      do_access("sw10", 1'b1, F_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, a0, r0);
      do_access("lw10", 1'b0, F_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, a0, r0);

      // Byte store into lane 3, then lane/extension variants
      do_access("sb13",  1'b1, F_B,  32'h13, 32'hFFFF_FF80, 32'h0, 1'b0, a0, r0);
      do_access("lb13",  1'b0, F_B,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, a0, r0);
      do_access("lbu13", 1'b0, F_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, a0, r0);
      do_access("lw10b", 1'b0, F_W,  32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);
      do_access("lhu12", 1'b0, F_HU, 32'h12, 32'h0, 32'h0000_80AD, 1'b0, a0, r0);
      do_access("lh12",  1'b0, F_H,  32'h12, 32'h0, 32'hFFFF_80AD, 1'b0, a0, r0);
      do_access("lbu10", 1'b0, F_BU, 32'h10, 32'h0, 32'h0000_00EF, 1'b0, a0, r0);

      // Address wrap modulo 1 KiB
      do_access("lw410",  1'b0, F_W, 32'h0000_0410, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);
      do_access("lw8010", 1'b0, F_W, 32'h8000_0010, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);

      // Back-to-back with valid held high across DONE
      idle_cycle();
      do_access("b2b0", 1'b0, F_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);
      do_access("b2b1", 1'b0, F_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, a1, r1);
      check_value("b2b accept gap", 32'(a1 - a0), 32'd3);
      check_value("b2b resp0",      32'(r0 - a0), 32'd2);
      check_value("b2b resp1",      32'(r1 - a0), 32'd5);

      // Misaligned accesses
`ifdef DMEM_MISALIGN_CHK_EN
      do_access("mis lw12", 1'b0, F_W, 32'h12, 32'h0, 32'h0, 1'b1, a0, r0);
      do_access("mis sw11", 1'b1, F_W, 32'h11, 32'h1234_5678, 32'h0, 1'b1, a0, r0);
      do_access("mis lw10", 1'b0, F_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);
      do_access("mis lh13", 1'b0, F_H, 32'h13, 32'h0, 32'h0, 1'b1, a0, r0);
`else
      do_access("mis lw12", 1'b0, F_W, 32'h12, 32'h0, 32'h80AD_BEEF, 1'b0, a0, r0);
      do_access("mis sw11", 1'b1, F_W, 32'h11, 32'h1234_5678, 32'h0, 1'b0, a0, r0);
      do_access("mis lw10", 1'b0, F_W, 32'h10, 32'h0, 32'h1234_5678, 1'b0, a0, r0);
      do_access("mis lh13", 1'b0, F_H, 32'h13, 32'h0, 32'h0000_1234, 1'b0, a0, r0);
`endif

      // Reset during BUSY discards the pending store
      do_access("sw20a", 1'b1, F_W, 32'h20, 32'h1111_1111, 32'h0, 1'b0, a0, r0);
      @(negedge clk);
      ReqValidM  = 1'b1;
      ReqWriteM  = 1'b1;
      Funct3M    = F_W;
      AddrM      = 32'h20;
      WriteDataM = 32'h2222_2222;
      @(negedge clk);
      #1;
      check_value("rstmid busy stall", {31'd0, StallM}, 32'd1);
      reset     = 1'b1;
      ReqValidM = 1'b0;
      @(negedge clk);
      #1;
      check_value("rstmid ReqReady",  {31'd0, ReqReady},  32'd1);
      check_value("rstmid RespValid", {31'd0, RespValid}, 32'd0);
      check_value("rstmid StallM",    {31'd0, StallM},    32'd0);
      reset = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         if (RespValid) seen = 1'b1;
      end
      check_value("rstmid no resp", {31'd0, seen}, 32'd0);
      do_access("lw20", 1'b0, F_W, 32'h20, 32'h0, 32'h1111_1111, 1'b0, a0, r0);

      idle_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V pipeline's memory stage. It accepts one load or store request per instruction over a valid/ready handshake, models a configurable access latency, and returns formatted load data (ReadDataM) that is latched into the MEM/WB register. It also drives StallM to the hazard unit, which freezes the front of the pipeline while an access is in flight.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two, minimum 4.
- LATENCY, 2: cycles from the acceptance cycle to the RespValid cycle; range 1..15.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ReqValidM  input  1  memory stage presents a load or store.
- ReqWriteM  input  1  1 selects a store, 0 selects a load.
- Funct3M  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- AddrM  input  32  byte address.
- WriteDataM  input  32  store data, right-aligned.
- ReqReady  output  1  responder can accept a request this cycle.
- StallM  output  1  pipeline must hold (request pending, no response yet).
- RespValid  output  1  one-cycle pulse; access complete.
- ReadDataM  output  32  formatted load data; held until the next response.
- MisalignM  output  1  misaligned-access flag, valid with RespValid.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: ReqReady=1. If ReqValidM=1, latch ReqWriteM, Funct3M, AddrM and WriteDataM, then go to BUSY. If LATENCY=1, go directly to DONE.
- BUSY: a counter loaded with LATENCY-1 decrements each cycle. On the cycle it reaches 1, the next state is DONE. Inputs are ignored in this state, including a ReqValidM that drops or changes.
- DONE: lasts one cycle. RespValid=1, ReqReady=0. The ReqValidM still presented here belongs to the same instruction and must not be re-accepted. Next state is IDLE.
- StallM = (IDLE && ReqValidM) || BUSY. StallM is 0 in DONE.
- Commit rule: on the clock edge that enters DONE, the array read is sampled, the store is written, and ReadDataM and MisalignM are registered.
- Word index = latched AddrM[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Loads:
  - Select the byte or halfword lane with AddrM[1:0].
  - B and H are sign-extended; BU and HU are zero-extended; W returns the full word.
  - Undefined Funct3 values are treated as W.
- Stores:
  - B writes WriteDataM[7:0] into lane AddrM[1:0].
  - H writes WriteDataM[15:0] into lane AddrM[1].
  - W writes the full word.
  - Other lanes are untouched. A store returns ReadDataM=0.
- Misaligned access: H with AddrM[0]=1, or W with AddrM[1:0]≠0. Handling is defined under Configuration.
- Reset:
  - State becomes IDLE; ReqReady=1; StallM, RespValid and MisalignM are 0; ReadDataM is 0.
  - Array contents are not reset.
  - A request in flight (BUSY) is discarded, and its store is never written.

## Timing
- Request accepted in cycle t produces RespValid in cycle t+LATENCY.
- StallM is high for cycles t..t+LATENCY-1.
- Back-to-back requests: the next acceptance is no earlier than cycle t+LATENCY+1, so throughput is one access per LATENCY+1 cycles.
- Read-after-write to the same word in consecutive requests returns the new data.
- If reset and ReqValidM are both high, reset wins and nothing is accepted.

## Configuration
- DMEM_MISALIGN_CHK_EN defined:
  - A misaligned access completes with normal timing and MisalignM=1 in the DONE cycle.
  - A misaligned store is suppressed, and a misaligned load returns ReadDataM=0.
- DMEM_MISALIGN_CHK_EN undefined:
  - MisalignM is tied to 0.
  - Offset bits are truncated to natural alignment: AddrM[0] is ignored for H, and AddrM[1:0] are ignored for W. The access then proceeds normally.

## Test plan
- Reset: hold reset for 2 cycles -> ReqReady=1, StallM=0, RespValid=0, ReadDataM=0x00000000, MisalignM=0.
- LATENCY=2: SW 0xDEADBEEF to 0x10 accepted in cycle 0 -> StallM=1 in cycles 0–1, RespValid in cycle 2. Then LW 0x10 -> ReadDataM=0xDEADBEEF with RespValid.
- SB 0x80 to 0x13 after the previous test, then:
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LW 0x10 -> 0x80ADBEEF.
  - LHU 0x12 -> 0x000080AD.
- Back-to-back: two LWs with ReqValidM held high throughout -> acceptances in cycles 0 and 3, RespValid in cycles 2 and 5, and no duplicate acceptance in DONE.
- Misaligned LW 0x12 after the previous tests:
  - With the macro -> MisalignM=1, ReadDataM=0.
  - Without the macro -> ReadDataM=0x80ADBEEF.
  - With the macro, SW 0x11 of 0x12345678 -> a subsequent LW 0x10 is unchanged.
- Reset mid-access: SW 0x11111111 to 0x20 completes, then SW 0x22222222 to 0x20 has reset asserted in its BUSY cycle. Result -> IDLE next cycle, RespValid never pulses, and LW 0x20 returns 0x11111111.
